// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Mealy serial sequence detector.
// Matches a qualified bit stream against a loadable PAT_W-bit pattern.
// Ports:
//   clk, rst          clock, async active-high reset
//   in, in_valid      serial bit and its qualifier
//   overlap           1 = overlapping, 0 = non-overlapping detection
//   pat_load/pat_data load a new pattern (MSB received first)
//   count_clr         synchronous clear of the match counter
//   out               combinational match, out_q its registered copy
//   match_count       saturating match counter
// Optional feature macro: SEQDET_COUNT_EN (match counter present).
module seq_detector_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_data,
    input  logic             count_clr,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] r_hist;
    logic [FW-1:0]    r_fill;
    logic [PAT_W-1:0] r_pat;
    logic             r_out_q;

    logic [PAT_W-1:0] w_shift;
    logic             w_full;
    logic             w_match;

    // Candidate window: stored history with the current bit appended.
    assign w_shift = {r_hist, in};
    assign w_full  = (r_fill == FILL_MAX);
    assign w_match = in_valid & ~pat_load & w_full & (w_shift == r_pat);

    assign out   = w_match;
    assign out_q = r_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= PATTERN;
            r_out_q <= 1'b0;
        end else begin
            r_out_q <= w_match;
            if (pat_load) begin
                // Bit presented in a load cycle is discarded.
                r_pat  <= pat_data;
                r_fill <= '0;
            end else if (in_valid) begin
                r_hist <= w_shift[PAT_W-2:0];
                // Non-overlapping: a match empties the history window.
                if (w_match && !overlap) begin
                    r_fill <= '0;
                end else if (!w_full) begin
                    r_fill <= r_fill + FW'(1);
                end
            end
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match_count = r_count;
`else
    logic w_unused;

    assign w_unused    = count_clr;
    assign match_count = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial sequence detector, the generalised successor of the fixed 4-bit "1101" detector. It compares a qualified serial bit stream against a runtime-loadable pattern of PAT_W bits, with overlapping or non-overlapping detection selectable per cycle. It flags each match combinationally (Mealy) and with a registered copy, and optionally counts matches. It sits between a serial front end and control logic that reacts to framing or sync words.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1101: reset value of the pattern register; the MSB is the first bit received.
- CNT_W, 8: match counter width.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies `in`; the bit is consumed only when this is high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on each consumed bit.
- pat_load  input  1  loads `pat_data` into the pattern register.
- pat_data  input  PAT_W  new pattern; MSB is the first bit.
- count_clr  input  1  synchronous clear of the match counter.
- out  output  1  Mealy match, combinational.
- out_q  output  1  `out` registered by one cycle.
- match_count  output  CNT_W  number of matches, saturating.

## Operation
- State:
  - `hist`, PAT_W-1 bits: the most recent consumed bits; the LSB is the newest.
  - `fill`: the number of valid history bits, saturating at PAT_W-1.
  - `pat`: the pattern register.
- `out` = in_valid & ~pat_load & (fill == PAT_W-1) & ({hist, in} == pat).
- On a consumed bit with pat_load low:
  - `hist` <= {hist[PAT_W-3:0], in}.
  - `fill` increments, saturating at PAT_W-1.
- Overlap behaviour when `out` is 1:
  - overlap=1: history advances normally, so the suffix of the match can start the next match.
  - overlap=0: `fill` <= 0, so the next match needs PAT_W fresh bits.
- in_valid low: state holds and `out` = 0. Idle gaps do not break a partial match.
- pat_load high:
  - `pat` <= pat_data, and `fill` <= 0.
  - The `in` bit of that cycle is discarded, even if in_valid is high.
  - `out` = 0 that cycle.
- Matching is by direct comparison of the history against `pat`. There is no explicit state enumeration, and any pattern (for example all-ones) is handled.

## Timing
- Reset values:
  - pat = PATTERN.
  - hist = 0 and fill = 0.
  - out_q = 0 and match_count = 0.
  - `out` is 0 while reset is held, because fill = 0.
- Latency:
  - `out` is asserted in the same cycle the final pattern bit is presented; there is zero latency.
  - `out_q` and the `match_count` increment follow on the next rising edge.
- After reset or a pattern load, the first possible `out` is the PAT_W-th consumed bit.
- Counter behaviour:
  - match_count saturates at 2^CNT_W-1 and does not wrap.
  - If count_clr and a match occur in the same cycle, the clear wins and match_count = 0.
- Reset asserted mid-stream clears all state asynchronously. Partial matches are lost.
- A change of `overlap` takes effect on the bit consumed in that cycle.

## Configuration
- SEQDET_COUNT_EN defined: the match counter and `count_clr` logic are implemented as described above.
- SEQDET_COUNT_EN undefined: no counter is synthesised, `match_count` is tied to 0, and `count_clr` is ignored. `out` and `out_q` are unaffected.

## Test plan
- Default pattern 1101, overlap=1, stream 1101101 with in_valid=1 throughout -> `out` is high on bits 4 and 7, and match_count = 2.
- Same stream with overlap=0 -> `out` is high on bit 4 only, and match_count = 1.
- Stream 1,1,gap,0,1 with in_valid low during the gap -> `out` is high on the final bit; the gap does not reset detection.
- Load pat_data=4'b1111 (with PAT_W=4) while in_valid=1 and in=1, then feed 1111 -> `out` stays 0 in the load cycle and is high on the 4th bit after the load.
- Assert rst after 110 has been received, then feed 1 -> no match. Then feed 1101 -> match on its 4th bit.
- CNT_W=2 with 5 matches, then count_clr coincident with a 6th match -> match_count holds at 3 after the 3rd match, then reads 0 after the clear. With SEQDET_COUNT_EN undefined, match_count stays 0 throughout.
